// File: rtl/cdb_pkg.sv
// cdb_pkg: shared common-data-bus constants and packet type, used by the
// CDB arbiter, the common_data_bus and the reservation stations.
package cdb_pkg;

   localparam int CDB_TAG_W  = 5;
   localparam int CDB_DATA_W = 32;

   // One broadcast on the common data bus.
   typedef struct packed {
      logic                  valid;
      logic [CDB_TAG_W-1:0]  tag;
      logic [CDB_DATA_W-1:0] data;
   } cdb_pkt_t;

   // Successor of slot k in a ring of n slots.
   function automatic int rr_next(input int k, input int n);
      return (k + 1 >= n) ? 0 : k + 1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_rr.sv
// rr_arbiter: N-way round-robin arbiter. Scans the request vector starting
// at the pointer, issues at most one one-hot grant per cycle and moves the
// pointer just past the granted index. The pointer holds when nothing is
// granted.
module rr_arbiter
   import cdb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req_i,
   output logic [N-1:0] grant_o
);

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;
   logic [N-1:0]     grant_d;
   logic [PTR_W-1:0] idx_c;
   int               sum_c;
   logic             found_c;

   // Find the first requester at or after the pointer, wrapping around.
   always_comb begin
      grant_d = '0;
      ptr_d   = ptr_q;
      idx_c   = '0;
      sum_c   = 0;
      found_c = 1'b0;
      for (int off = 0; off < N; off++) begin
         sum_c = int'(ptr_q) + off;
         if (sum_c >= N) begin
            sum_c = sum_c - N;
         end
         idx_c = PTR_W'(sum_c);
         if (!found_c && req_i[idx_c]) begin
            found_c        = 1'b1;
            grant_d[idx_c] = 1'b1;
            ptr_d          = PTR_W'(rr_next(sum_c, N));
         end
      end
   end

   // Pointer register.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign grant_o = grant_d;

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: producer-side front end of the common data bus. Each
// functional unit owns a one-entry holding slot; full slots are granted
// round-robin, one per cycle, and the winner is broadcast through a
// registered single-cycle output toward common_data_bus.
// Optional feature macro: CDB_ARB_FLUSH_EN adds a flush input that empties
// every slot and suppresses the next broadcast.
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int TAG_W   = CDB_TAG_W,
   parameter int DATA_W  = CDB_DATA_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SRC-1:0]        src_valid,
   input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   output logic [NUM_SRC-1:0]        src_ready,
   output logic                      cdb_valid,
   output logic [TAG_W-1:0]          cdb_tag,
   output logic [DATA_W-1:0]         cdb_data
`ifdef CDB_ARB_FLUSH_EN
   ,
   input  logic                      flush
`endif
);

   // Slot state: valid bits are control, tag/data are payload.
   logic [NUM_SRC-1:0] hold_v_q;
   logic [NUM_SRC-1:0] hold_v_d;
   logic [TAG_W-1:0]   hold_tag_q  [NUM_SRC];
   logic [DATA_W-1:0]  hold_data_q [NUM_SRC];

   logic [NUM_SRC-1:0] req;
   logic [NUM_SRC-1:0] grant;
   logic [NUM_SRC-1:0] ready;
   logic [NUM_SRC-1:0] accept;
   logic               flush_w;

   logic               gnt_any;
   logic [TAG_W-1:0]   gnt_tag;
   logic [DATA_W-1:0]  gnt_data;

   logic               cdb_valid_q, cdb_valid_d;
   logic [TAG_W-1:0]   cdb_tag_q,   cdb_tag_d;
   logic [DATA_W-1:0]  cdb_data_q,  cdb_data_d;

`ifdef CDB_ARB_FLUSH_EN
   assign flush_w = flush;
`else
   assign flush_w = 1'b0;
`endif

   // A flush cycle issues no grant, so the pointer stays where it was.
   assign req = hold_v_q & {NUM_SRC{~flush_w}};

   rr_arbiter #(
      .N (NUM_SRC)
   ) u_rr (
      .clk     (clk),
      .rst     (rst),
      .req_i   (req),
      .grant_o (grant)
   );

   // Ready when the slot is empty or is being drained this cycle; a flush
   // refuses everything so offered results are dropped.
   always_comb begin
      ready  = (~hold_v_q | grant) & {NUM_SRC{~flush_w}};
      accept = src_valid & ready;
   end

   // Slot occupancy: a reload on a granted slot keeps it full.
   always_comb begin
      hold_v_d = '0;
      if (!flush_w) begin
         hold_v_d = (hold_v_q & ~grant) | accept;
      end
   end

   // One-hot grant selects the broadcast payload.
   always_comb begin
      gnt_tag  = '0;
      gnt_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant[i]) begin
            gnt_tag  = gnt_tag  | hold_tag_q[i];
            gnt_data = gnt_data | hold_data_q[i];
         end
      end
      gnt_any = |grant;
   end

   // Output register next state: tag/data hold when nothing is granted.
   always_comb begin
      cdb_valid_d = gnt_any;
      cdb_tag_d   = cdb_tag_q;
      cdb_data_d  = cdb_data_q;
      if (gnt_any) begin
         cdb_tag_d  = gnt_tag;
         cdb_data_d = gnt_data;
      end
   end

   // Control state and broadcast register, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_v_q    <= '0;
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_data_q  <= '0;
      end else begin
         hold_v_q    <= hold_v_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_tag_q   <= cdb_tag_d;
         cdb_data_q  <= cdb_data_d;
      end
   end

   // Slot payload capture; meaningless while the slot's valid bit is clear.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SRC; i++) begin
         if (accept[i]) begin
            hold_tag_q[i]  <= src_tag[i*TAG_W +: TAG_W];
            hold_data_q[i] <= src_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign src_ready = ready;
   assign cdb_valid = cdb_valid_q;
   assign cdb_tag   = cdb_tag_q;
   assign cdb_data  = cdb_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scenario tasks for cdb_arbiter with a scoreboard of
// accepted results that each broadcast must consume exactly once.
module tb_cdb_arbiter;

   localparam int NS = 4;
   localparam int TW = 5;
   localparam int DW = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [NS-1:0]    src_valid;
   logic [NS*TW-1:0] src_tag;
   logic [NS*DW-1:0] src_data;
   logic [NS-1:0]    src_ready;
   logic             cdb_valid;
   logic [TW-1:0]    cdb_tag;
   logic [DW-1:0]    cdb_data;
`ifdef CDB_ARB_FLUSH_EN
   logic             flush;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
   } ent_t;

   ent_t pend_q[$];

   cdb_arbiter #(
      .NUM_SRC (NS),
      .TAG_W   (TW),
      .DATA_W  (DW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .src_valid (src_valid),
      .src_tag   (src_tag),
      .src_data  (src_data),
      .src_ready (src_ready),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data)
`ifdef CDB_ARB_FLUSH_EN
      ,
      .flush     (flush)
`endif
   );

   always #5 clk = ~clk;

   // Remove a matching pending entry; returns 0 if none was outstanding.
   function automatic bit sb_take(input logic [TW-1:0] t, input logic [DW-1:0] d);
      for (int k = 0; k < pend_q.size(); k++) begin
         if (pend_q[k].tag == t && pend_q[k].data == d) begin
            pend_q.delete(k);
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   // Record every handshake visible this cycle as an expected broadcast.
   task automatic sb_push_fires(output logic [NS-1:0] fired);
      fired = src_valid & src_ready;
      for (int i = 0; i < NS; i++) begin
         if (fired[i]) begin
            pend_q.push_back({src_tag[i*TW +: TW], src_data[i*DW +: DW]});
         end
      end
   endtask

   task automatic drive_idle();
      src_valid = '0;
      src_tag   = '0;
      src_data  = '0;
   endtask

   task automatic offer(input int s, input logic [TW-1:0] t, input logic [DW-1:0] d);
      src_valid[s]       = 1'b1;
      src_tag[s*TW +: TW] = t;
      src_data[s*DW +: DW] = d;
   endtask

   task automatic do_reset();
      drive_idle();
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      pend_q.delete();
   endtask

   task automatic test_reset();
      drive_idle();
`ifdef CDB_ARB_FLUSH_EN
      flush = 1'b0;
`endif
      rst = 1'b1;
      repeat (10) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", cdb_valid); end
      total++; if (cdb_tag !== 5'd0) begin bad++; $display("FAIL reset_tag got=%0d want=0", cdb_tag); end
      total++; if (cdb_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h want=0", cdb_data); end
      total++; if (src_ready !== 4'b1111) begin bad++; $display("FAIL reset_ready got=%b want=1111", src_ready); end
   endtask

   task automatic test_single_source();
      logic [NS-1:0] f;
      do_reset();
      offer(2, 5'd9, 32'hDEADBEEF);
      @(negedge clk);
      total++; if (src_ready[2] !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", src_ready[2]); end
      sb_push_fires(f);
      @(posedge clk);
      #1 drive_idle();
      @(negedge clk);
      total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL single_n1_valid got=%b want=0", cdb_valid); end
      @(negedge clk);
      total++; if (cdb_valid !== 1'b1) begin bad++; $display("FAIL single_n2_valid got=%b want=1", cdb_valid); end
      total++;
      if (!(cdb_valid === 1'b1 && sb_take(cdb_tag, cdb_data))) begin
         bad++; $display("FAIL single_n2_payload got tag=%0d data=%h want tag=9 data=deadbeef", cdb_tag, cdb_data);
      end
      @(negedge clk);
      total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL single_n3_valid got=%b want=0", cdb_valid); end
      total++; if (cdb_tag !== 5'd9 || cdb_data !== 32'hDEADBEEF) begin
         bad++; $display("FAIL single_hold got tag=%0d data=%h want tag=9 data=deadbeef", cdb_tag, cdb_data);
      end
      total++; if (pend_q.size() != 0) begin bad++; $display("FAIL single_pending got=%0d want=0", pend_q.size()); end
   endtask

   task automatic test_round_robin();
      logic [NS-1:0] f;
      int nb = 0;
      int nacc = 0;
      do_reset();
      for (int i = 0; i < NS; i++) offer(i, TW'(i + 1), 32'hC0DE0000 | DW'(i + 1));
      for (int cyc = 0; cyc < 22; cyc++) begin
         @(negedge clk);
         if (cyc >= 2 && cyc <= 13) begin
            total++; if (cdb_valid !== 1'b1) begin bad++; $display("FAIL rr_gap cyc=%0d got=%b want=1", cyc, cdb_valid); end
         end
         if (cdb_valid === 1'b1) begin
            total++;
            if (cdb_tag !== TW'((nb % NS) + 1)) begin
               bad++; $display("FAIL rr_order n=%0d got=%0d want=%0d", nb, cdb_tag, (nb % NS) + 1);
            end
            total++;
            if (!sb_take(cdb_tag, cdb_data)) begin
               bad++; $display("FAIL rr_unexpected got tag=%0d data=%h want=pending", cdb_tag, cdb_data);
            end
            nb++;
         end
         sb_push_fires(f);
         nacc += $countones(f);
         @(posedge clk);
         #1;
         if (cyc == 11) drive_idle();
      end
      total++; if (pend_q.size() != 0) begin bad++; $display("FAIL rr_lost got=%0d want=0", pend_q.size()); end
      total++; if (nb != nacc) begin bad++; $display("FAIL rr_count got=%0d want=%0d", nb, nacc); end
   endtask

   task automatic test_backpressure();
      logic [NS-1:0] f;
      int c0 = 0;
      int c1 = 0;
      int nb = 0;
      int src;
      do_reset();
      for (int t = 0; t < 40; t++) begin
         drive_idle();
         if (c0 < 8) offer(0, TW'(c0 + 1), 32'h10000000 + DW'(c0));
         if (c1 < 8) offer(1, TW'(c1 + 9), 32'h20000000 + DW'(c1));
         @(negedge clk);
         if (cdb_valid === 1'b1) begin
            src = (cdb_tag <= 5'd8) ? 0 : 1;
            total++; if (src != nb % 2) begin bad++; $display("FAIL bp_alternate n=%0d got=%0d want=%0d", nb, src, nb % 2); end
            total++;
            if (!sb_take(cdb_tag, cdb_data)) begin
               bad++; $display("FAIL bp_unexpected got tag=%0d data=%h want=pending", cdb_tag, cdb_data);
            end
            nb++;
         end
         if (t >= 1 && t <= 12) begin
            total++;
            if (src_ready[1:0] !== ((t % 2 == 1) ? 2'b01 : 2'b10)) begin
               bad++; $display("FAIL bp_ready t=%0d got=%b want=%b", t, src_ready[1:0], (t % 2 == 1) ? 2'b01 : 2'b10);
            end
         end
         sb_push_fires(f);
         @(posedge clk);
         #1;
         if (f[0]) c0++;
         if (f[1]) c1++;
      end
      drive_idle();
      total++; if (nb != 16) begin bad++; $display("FAIL bp_count got=%0d want=16", nb); end
      total++; if (pend_q.size() != 0) begin bad++; $display("FAIL bp_lost got=%0d want=0", pend_q.size()); end
      total++; if (c0 != 8 || c1 != 8) begin bad++; $display("FAIL bp_accepts got=%0d/%0d want=8/8", c0, c1); end
   endtask

   task automatic test_same_cycle_reload();
      logic [NS-1:0] f;
      logic [TW-1:0] exp_tag [3];
      exp_tag[0] = 5'd19;
      exp_tag[1] = 5'd7;
      exp_tag[2] = 5'd20;
      do_reset();
      offer(3, 5'd19, 32'h33330013);
      @(negedge clk);
      sb_push_fires(f);
      @(posedge clk);
      #1;
      drive_idle();
      offer(3, 5'd20, 32'h33330014);
      offer(0, 5'd7, 32'h00000007);
      @(negedge clk);
      total++; if (src_ready[3] !== 1'b1) begin bad++; $display("FAIL reload_ready_grant got=%b want=1", src_ready[3]); end
      total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL reload_c1_valid got=%b want=0", cdb_valid); end
      sb_push_fires(f);
      @(posedge clk);
      #1 drive_idle();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (c == 0) begin
            total++; if (src_ready[3] !== 1'b0) begin bad++; $display("FAIL reload_slot_full got=%b want=0", src_ready[3]); end
         end
         total++;
         if (cdb_valid !== 1'b1 || cdb_tag !== exp_tag[c] || !sb_take(cdb_tag, cdb_data)) begin
            bad++; $display("FAIL reload_bcast c=%0d got v=%b tag=%0d want v=1 tag=%0d", c, cdb_valid, cdb_tag, exp_tag[c]);
         end
      end
      @(negedge clk);
      total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL reload_tail got=%b want=0", cdb_valid); end
      total++; if (pend_q.size() != 0) begin bad++; $display("FAIL reload_lost got=%0d want=0", pend_q.size()); end
   endtask

   task automatic test_reset_mid_op();
      bit seen = 1'b0;
      do_reset();
      offer(0, 5'd11, 32'hB0000011);
      offer(1, 5'd12, 32'hB0000012);
      offer(2, 5'd13, 32'hB0000013);
      @(posedge clk);
      #1 drive_idle();
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", cdb_valid); end
      total++; if (cdb_tag !== 5'd0) begin bad++; $display("FAIL midrst_tag got=%0d want=0", cdb_tag); end
      total++; if (src_ready !== 4'b1111) begin bad++; $display("FAIL midrst_ready got=%b want=1111", src_ready); end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (cdb_valid === 1'b1) seen = 1'b1;
      end
      total++; if (seen) begin bad++; $display("FAIL midrst_drop got=broadcast want=none"); end
      pend_q.delete();
   endtask

`ifdef CDB_ARB_FLUSH_EN
   task automatic test_flush();
      bit seen = 1'b0;
      flush = 1'b0;
      do_reset();
      offer(0, 5'd21, 32'hF0000021);
      offer(1, 5'd22, 32'hF0000022);
      offer(2, 5'd23, 32'hF0000023);
      @(posedge clk);
      #1 drive_idle();
      offer(3, 5'd24, 32'hF0000024);
      flush = 1'b1;
      @(negedge clk);
      total++; if (src_ready !== 4'b0000) begin bad++; $display("FAIL flush_ready got=%b want=0000", src_ready); end
      @(posedge clk);
      #1 flush = 1'b0;
      drive_idle();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL flush_valid c=%0d got=%b want=0", c, cdb_valid); end
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (cdb_valid === 1'b1) seen = 1'b1;
      end
      total++; if (seen) begin bad++; $display("FAIL flush_drop got tag=%0d want=none", cdb_tag); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_source();
      test_round_robin();
      test_backpressure();
      test_same_cycle_reload();
      test_reset_mid_op();
`ifdef CDB_ARB_FLUSH_EN
      test_flush();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Producer-side front end of the common data bus. Collects completed results (tag + data) from `NUM_SRC` functional units, holds each in a one-entry slot, and grants one slot per cycle round-robin. The granted result is driven as a registered single-cycle broadcast into `common_data_bus` (`valid_in` / `tag_in` / `data_in`). Sits between the execution units and the bus; functional units stall via per-source ready.

## Interface

Parameters:
- `NUM_SRC`, default 4: number of functional-unit sources, 2..8.
- `TAG_W`, default 5: reservation-station tag width.
- `DATA_W`, default 32: result width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `src_valid`  in  NUM_SRC  per-source result valid.
- `src_tag`  in  NUM_SRC*TAG_W  per-source tag, source i at bits [i*TAG_W +: TAG_W].
- `src_data`  in  NUM_SRC*DATA_W  per-source data, same packing scheme.
- `src_ready`  out  NUM_SRC  per-source accept.
- `cdb_valid`  out  1  broadcast valid, to `common_data_bus.valid_in`.
- `cdb_tag`  out  TAG_W  broadcast tag.
- `cdb_data`  out  DATA_W  broadcast data.
- `flush`  in  1  present only with `CDB_ARB_FLUSH_EN`.

## Operation

- **Slot state.** Each source i has a slot: `hold_v[i]`, `hold_tag[i]`, `hold_data[i]`.
- **Ready.** `src_ready[i] = ~hold_v[i] | grant[i]` (combinational).
  - A slot that is granted this cycle accepts a new result in the same cycle.
- **Accept.** A transfer occurs when `src_valid[i] & src_ready[i]`; the slot loads tag and data and sets `hold_v[i]`.
  - Grant and accept on the same slot in one cycle: the slot ends full with the new result.
- **Arbitration.** Round-robin over the slots with `hold_v` set, starting at pointer `rr_ptr`.
  - At most one grant per cycle.
  - After a grant to slot k, `rr_ptr` becomes `(k+1) mod NUM_SRC`.
  - With no grant, `rr_ptr` holds.
- **Output register.** On a grant, the output registers load the granted slot's tag and data with `cdb_valid` = 1, and the slot clears unless it is reloaded that cycle. With no grant, `cdb_valid` = 0 and `cdb_tag` / `cdb_data` hold their previous values.
- **Starvation bound.** A full slot is granted within `NUM_SRC` cycles.
- **Tag uniqueness.** Tags are not checked; the rename logic guarantees uniqueness.

## Timing

- **Reset values.** `hold_v` = 0, `rr_ptr` = 0, `cdb_valid` = 0, `cdb_tag` = 0, `cdb_data` = 0. `src_ready` is therefore all-ones in the first cycle after reset.
- **Latency.** A result accepted at edge N is in its slot during cycle N+1. If granted then, `cdb_valid` is high during cycle N+2 (minimum latency 2 cycles).
- **Throughput.** One broadcast per cycle when any slot is full. Each source sustains one result per cycle only when it is granted every cycle.
- **Simultaneous requests.** With all slots full, grants rotate 0, 1, 2, 3, 0, ...
- **Reset mid-operation.** All pending slot contents are dropped. No broadcast occurs in the cycle following the reset edge.

## Configuration

Macro: `CDB_ARB_FLUSH_EN`.
- **Defined.** The `flush` input exists. When `flush` = 1 at an edge:
  - all `hold_v` clear and `cdb_valid` is 0 next cycle;
  - inputs offered in the flush cycle are discarded;
  - `src_ready` is forced to 0 during the flush cycle;
  - `rr_ptr` is unchanged.
- **Undefined.** No `flush` port; only `rst` clears the slots.

## Structure

- **Package `cdb_pkg`.**
  - Constants: `CDB_TAG_W` = 5, `CDB_DATA_W` = 32.
  - Typedef `cdb_pkt_t`: struct {valid, tag, data}, shared with `common_data_bus` and the reservation stations.
- **Sub-module `rr_arbiter`.** Parameterised by N. Request vector in; one-hot grant and pointer update out. Contains the pointer register and uses the same `clk` / `rst`.
- The slots and the output register stay in `cdb_arbiter`.

## Test plan

- **Reset.** `rst` held 10 cycles, then released with all `src_valid` = 0 → `cdb_valid` = 0, `cdb_tag` = 0, `cdb_data` = 0, `src_ready` = 4'b1111.
- **Single source.** src 2 offers tag 5'd9, data 32'hDEADBEEF for one cycle at edge N → `cdb_valid` = 1 during N+2 only, with `cdb_tag` = 9 and `cdb_data` = 32'hDEADBEEF.
- **Round-robin.** All 4 sources valid continuously with tags 1, 2, 3, 4 → broadcast tag order 1, 2, 3, 4, 1, 2, ...; `cdb_valid` stays high with no gaps.
- **Backpressure.** Sources 0 and 1 valid every cycle, 8 results each → 16 broadcasts, alternating sources. Each source sees `src_ready` = 0 on the cycles its slot is full and not granted. No result is lost or duplicated.
- **Same-cycle reload.** Slot 3 is granted while src 3 offers tag 5'd20 → next grant of slot 3 broadcasts tag 20, and `hold_v[3]` never drops.
- **Flush (`CDB_ARB_FLUSH_EN`).** With 3 slots full, pulse `flush` → `cdb_valid` = 0 for the next 2 cycles and none of the 3 tags ever appear on the bus.
